// File: rtl/rx_sequencer.sv
// Receive-chain sequencer: restart/sweep/lock supervision plus a decoded-character FIFO.
// Optional feature macro: RX_SEQ_AUTO_RESTART_EN (idle relock in LOCKED, timed auto-restart from FAIL).
module rx_sequencer #(
    parameter int unsigned SWEEP_TIMEOUT_CYC = 6400000,
    parameter int unsigned IDLE_TIMEOUT_CYC  = 12800000,
    parameter int unsigned RESTART_CYC       = 4,
    parameter int unsigned MAX_RETRY         = 3,
    parameter int unsigned FIFO_DEPTH        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       sweep_done,
    input  logic [7:0] char_in,
    input  logic       char_valid_in,
    output logic       chain_en,
    output logic       chain_rst,
    output logic [7:0] out_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       locked,
    output logic       error,
    output logic       overflow,
    output logic [2:0] state
);

    localparam int unsigned SW_W = (SWEEP_TIMEOUT_CYC > 1) ? $clog2(SWEEP_TIMEOUT_CYC) : 1;
    localparam int unsigned RS_W = (RESTART_CYC > 1) ? $clog2(RESTART_CYC) : 1;
    localparam int unsigned RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
`ifdef RX_SEQ_AUTO_RESTART_EN
    localparam int unsigned ID_W = (IDLE_TIMEOUT_CYC > 1) ? $clog2(IDLE_TIMEOUT_CYC) : 1;
`endif

    localparam bit PARAMS_OK = (RESTART_CYC >= 1) && (MAX_RETRY >= 1) &&
                               (SWEEP_TIMEOUT_CYC >= 1) && (IDLE_TIMEOUT_CYC >= 1) &&
                               (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("rx_sequencer: invalid parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESTART = 3'd1,
        S_SWEEP   = 3'd2,
        S_LOCKED  = 3'd3,
        S_FAIL    = 3'd4
    } state_t;

    typedef struct packed {
        logic chain_en;
        logic chain_rst;
        logic locked;
        logic error;
    } flags_t;

    // Output flags are a pure function of the state being entered.
    function automatic flags_t flags_of(input state_t s);
        flags_t f;
        f.chain_en  = (s == S_SWEEP) || (s == S_LOCKED);
        f.chain_rst = (s == S_RESTART);
        f.locked    = (s == S_LOCKED);
        f.error     = (s == S_FAIL);
        return f;
    endfunction

    state_t            st;
    flags_t            flags;
    logic [RS_W-1:0]   rst_cnt;
    logic [SW_W-1:0]   sweep_tmr;
    logic [RT_W-1:0]   retry_cnt;
    logic [RT_W-1:0]   retry_inc;
    logic              retry_exhausted;
    logic              sweep_last;
`ifdef RX_SEQ_AUTO_RESTART_EN
    logic [ID_W-1:0]   idle_tmr;
`endif

    assign chain_en  = flags.chain_en;
    assign chain_rst = flags.chain_rst;
    assign locked    = flags.locked;
    assign error     = flags.error;
    assign state     = st;

    // Retry count saturates at MAX_RETRY so it can never wrap.
    assign retry_inc       = (32'(retry_cnt) < MAX_RETRY) ? retry_cnt + RT_W'(1) : retry_cnt;
    assign retry_exhausted = (32'(retry_inc) >= MAX_RETRY);
    assign sweep_last      = (sweep_tmr == SW_W'(SWEEP_TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= S_IDLE;
            flags     <= '0;
            rst_cnt   <= '0;
            sweep_tmr <= '0;
            retry_cnt <= '0;
`ifdef RX_SEQ_AUTO_RESTART_EN
            idle_tmr  <= '0;
`endif
        end else begin
            rst_cnt   <= '0;
            sweep_tmr <= '0;
`ifdef RX_SEQ_AUTO_RESTART_EN
            idle_tmr  <= '0;
`endif
            if (stop) begin
                st    <= S_IDLE;
                flags <= flags_of(S_IDLE);
            end else begin
                case (st)
                    S_IDLE: begin
                        retry_cnt <= '0;
                        if (start) begin
                            st    <= S_RESTART;
                            flags <= flags_of(S_RESTART);
                        end
                    end
                    S_RESTART: begin
                        if (rst_cnt == RS_W'(RESTART_CYC - 1)) begin
                            st    <= S_SWEEP;
                            flags <= flags_of(S_SWEEP);
                        end else begin
                            rst_cnt <= rst_cnt + RS_W'(1);
                        end
                    end
                    S_SWEEP: begin
                        if (sweep_done) begin
                            st        <= S_LOCKED;
                            flags     <= flags_of(S_LOCKED);
                            retry_cnt <= '0;
                        end else if (sweep_last) begin
                            retry_cnt <= retry_inc;
                            st        <= retry_exhausted ? S_FAIL : S_RESTART;
                            flags     <= flags_of(retry_exhausted ? S_FAIL : S_RESTART);
                        end else begin
                            sweep_tmr <= sweep_tmr + SW_W'(1);
                        end
                    end
                    S_LOCKED: begin
                        if (!sweep_done) begin
                            st        <= S_RESTART;
                            flags     <= flags_of(S_RESTART);
                            retry_cnt <= retry_inc;
                        end
`ifdef RX_SEQ_AUTO_RESTART_EN
                        else if (char_valid_in) begin
                            idle_tmr <= '0;
                        end else if (idle_tmr == ID_W'(IDLE_TIMEOUT_CYC - 1)) begin
                            st        <= S_RESTART;
                            flags     <= flags_of(S_RESTART);
                            retry_cnt <= retry_inc;
                        end else begin
                            idle_tmr <= idle_tmr + ID_W'(1);
                        end
`endif
                    end
                    S_FAIL: begin
                        if (start) begin
                            st        <= S_RESTART;
                            flags     <= flags_of(S_RESTART);
                            retry_cnt <= '0;
                        end
`ifdef RX_SEQ_AUTO_RESTART_EN
                        else if (sweep_last) begin
                            st        <= S_RESTART;
                            flags     <= flags_of(S_RESTART);
                            retry_cnt <= '0;
                        end else begin
                            sweep_tmr <= sweep_tmr + SW_W'(1);
                        end
`endif
                    end
                    default: begin
                        st    <= S_IDLE;
                        flags <= flags_of(S_IDLE);
                    end
                endcase
            end
        end
    end

    // Character FIFO: extra wrap bit on each pointer distinguishes full from empty.
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_nxt;
    logic [AW:0] rd_nxt;
    logic        full;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        drop;
    logic        flush;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = out_valid && out_ready;
    assign push_req = (st == S_LOCKED) && char_valid_in;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign flush    = start && !stop && ((st == S_IDLE) || (st == S_FAIL));
    assign wr_nxt   = flush ? '0 : (push ? wr_ptr + (AW+1)'(1) : wr_ptr);
    assign rd_nxt   = flush ? '0 : (pop  ? rd_ptr + (AW+1)'(1) : rd_ptr);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= char_in;
        end
    end

    // Head is pre-fetched so out_char is registered; bypass when the new head is being written now.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_char  <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            out_valid <= (wr_nxt != rd_nxt);
            if (wr_nxt != rd_nxt) begin
                out_char <= (rd_nxt == wr_ptr) ? char_in : mem[rd_nxt[AW-1:0]];
            end
            if (flush || (st == S_IDLE)) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_sequencer.sv
// Self-checking bench for rx_sequencer: directed sequencing scenarios plus randomized FIFO traffic against a queue model.
module tb_rx_sequencer;

    localparam int unsigned RC = 2;
    localparam int unsigned ST = 16;
    localparam int unsigned IT = 32;
    localparam int unsigned MR = 3;
    localparam int unsigned FD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       sweep_done;
    logic [7:0] char_in;
    logic       char_valid_in;
    logic       chain_en;
    logic       chain_rst;
    logic [7:0] out_char;
    logic       out_valid;
    logic       out_ready;
    logic       locked;
    logic       error;
    logic       overflow;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q[$];

    always #5 clk = ~clk;

    rx_sequencer #(
        .SWEEP_TIMEOUT_CYC (ST),
        .IDLE_TIMEOUT_CYC  (IT),
        .RESTART_CYC       (RC),
        .MAX_RETRY         (MR),
        .FIFO_DEPTH        (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .sweep_done    (sweep_done),
        .char_in       (char_in),
        .char_valid_in (char_valid_in),
        .chain_en      (chain_en),
        .chain_rst     (chain_rst),
        .out_char      (out_char),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .locked        (locked),
        .error         (error),
        .overflow      (overflow),
        .state         (state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bring the chain from any state to LOCKED via IDLE; sweep locks after 'delay' sweep cycles.
    task automatic do_lock(input int delay);
        int n;
        n = 0;
        sweep_done = 1'b0;
        stop = 1'b1;  tick(); stop = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        while (!chain_en && n < 20) begin
            tick();
            n++;
        end
        check("lock_chain_en", 32'(chain_en), 1);
        repeat (delay) tick();
        sweep_done = 1'b1;
        tick();
        check("lock_locked", 32'(locked), 1);
        check("lock_state", 32'(state), 3);
    endtask

    task automatic push_char(input logic [7:0] c);
        char_valid_in = 1'b1;
        char_in = c;
        tick();
        char_valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin
        int d;
        int cyc;
        int pulses;
        logic prev;
        logic pv;
        logic rdy;
        logic full_m;
        logic pop_m;
        logic ovf_exp;
        logic [7:0] ch;

        rst = 1'b1; start = 1'b0; stop = 1'b0; sweep_done = 1'b0;
        char_in = '0; char_valid_in = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        check("rst_state", 32'(state), 0);
        check("rst_chain_en", 32'(chain_en), 0);
        check("rst_chain_rst", 32'(chain_rst), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_char", 32'(out_char), 0);
        check("rst_flags", 32'({locked, error, overflow}), 0);
        rst = 1'b0;
        repeat (5) tick();

        // Basic lock: exact restart-pulse and enable timing.
        start = 1'b1; tick(); start = 1'b0;
        check("bl_rst_c1", 32'({chain_rst, chain_en}), 32'b10);
        tick();
        check("bl_rst_c2", 32'({chain_rst, chain_en}), 32'b10);
        tick();
        check("bl_en", 32'({chain_rst, chain_en}), 32'b01);
        check("bl_state_sweep", 32'(state), 2);
        d = $urandom_range(1, 10);
        start = 1'b1; tick(); start = 1'b0;
        check("bl_start_ignored", 32'(state), 2);
        repeat (d) tick();
        check("bl_not_locked", 32'(locked), 0);
        sweep_done = 1'b1;
        tick();
        check("bl_locked", 32'(locked), 1);
        check("bl_state_locked", 32'(state), 3);

        // Overflow: five pushes into a four-entry FIFO with the consumer stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_char(8'(8'h41 + i));
            if (i == 3) check("ov_not_yet", 32'(overflow), 0);
        end
        check("ov_head", 32'(out_char), 32'h41);
        check("ov_flag", 32'(overflow), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ov_drain_valid", 32'(out_valid), 1);
            check("ov_drain_char", 32'(out_char), 32'(8'h41 + i));
            tick();
        end
        check("ov_empty", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Full FIFO with push and pop in the same cycle.
        do_lock(2);
        check("pp_ovf_cleared", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) push_char(8'(8'h50 + i));
        out_ready = 1'b1;
        push_char(8'h54);
        check("pp_no_drop", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) begin
            check("pp_drain_valid", 32'(out_valid), 1);
            check("pp_drain_char", 32'(out_char), 32'(8'h51 + i));
            tick();
        end
        check("pp_empty", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Stop while locked keeps buffered characters drainable.
        do_lock(1);
        push_char(8'h61);
        push_char(8'h62);
        stop = 1'b1; tick(); stop = 1'b0;
        check("st_state", 32'(state), 0);
        check("st_chain_en", 32'(chain_en), 0);
        out_ready = 1'b1;
        check("st_c0", 32'({out_valid, out_char}), 32'h161);
        tick();
        check("st_c1", 32'({out_valid, out_char}), 32'h162);
        tick();
        check("st_empty", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Randomized push/pop traffic against a queue model.
        do_lock($urandom_range(0, 8));
        q.delete();
        ovf_exp = 1'b0;
        for (int c = 0; c < 250; c++) begin
            pv  = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            ch  = 8'($urandom);
            char_valid_in = pv;
            char_in = ch;
            out_ready = rdy;
            full_m = (q.size() == FD);
            pop_m  = rdy && (q.size() > 0);
            if (pop_m) void'(q.pop_front());
            if (pv) begin
                if (full_m && !pop_m) ovf_exp = 1'b1;
                else q.push_back(ch);
            end
            tick();
            check("rnd_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0) check("rnd_char", 32'(out_char), 32'(q[0]));
            check("rnd_ovf", 32'(overflow), 32'(ovf_exp));
        end
        char_valid_in = 1'b0;
        out_ready = 1'b0;

        // Lock loss goes straight back to RESTART.
        sweep_done = 1'b0;
        tick();
        check("ll_state", 32'(state), 1);
        check("ll_chain_rst", 32'(chain_rst), 1);

        // Idle behaviour in LOCKED.
        do_lock(0);
        repeat (IT - 1) tick();
        check("idle_still_locked", 32'(state), 3);
        tick();
`ifdef RX_SEQ_AUTO_RESTART_EN
        check("idle_relock", 32'(state), 1);
`else
        check("idle_stays_locked", 32'(state), 3);
`endif

        // Sweep failure: bounded retries then FAIL.
        sweep_done = 1'b0;
        stop = 1'b1;  tick(); stop = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        pulses = 1;
        prev = chain_rst;
        cyc = 0;
        while (!error && cyc < 200) begin
            tick();
            cyc++;
            if (chain_rst && !prev) pulses++;
            prev = chain_rst;
        end
        check("sf_pulses", 32'(pulses), MR);
        check("sf_cycles", 32'(cyc), MR * (RC + ST));
        check("sf_error", 32'({error, chain_en}), 32'b10);
        check("sf_state", 32'(state), 4);
        start = 1'b1; tick(); start = 1'b0;
        check("sf_restart", 32'({error, chain_rst}), 32'b01);
        check("sf_restart_state", 32'(state), 1);

        // Synchronous reset in the middle of operation.
        do_lock(0);
        push_char(8'h70);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mr_state", 32'(state), 0);
        check("mr_chain", 32'({chain_en, chain_rst}), 0);
        check("mr_fifo", 32'({out_valid, out_char}), 0);
        check("mr_flags", 32'({locked, error, overflow}), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
